// File: rtl/camera_frame_writer.sv
// Camera pixel stream to frame-RAM write port with live / armed-snapshot / frozen modes.
// Optional build macro CAMERA_FRAME_WRITER_MIRROR_EN: horizontally mirrored write addressing.
module camera_frame_writer #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [11:0]       pix_color,
    input  logic              snapshot_req,
    // "release" is a reserved word in SystemVerilog, hence the suffix
    input  logic              release_req,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              frame_done,
    output logic              frozen,
    output logic              short_frame,
    output logic              overrun
);

    localparam int COL_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int ROW_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LIVE, S_ARMED, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d, col_eff, col_term;
    logic [ROW_W-1:0]    row_q, row_d, row_eff;
    logic                full_q, full_d, full_eff;
    logic                started_q, started_d;
    logic                resync_q, resync_d, resync_eff;
    logic                snap_q, snap_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [11:0]         wr_data_q, wr_data_d;
    logic                frame_done_q, frame_done_d;
    logic                short_q, short_d;
    logic                overrun_q, overrun_d;
    logic                capture, accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            full_q       <= 1'b0;
            started_q    <= 1'b0;
            resync_q     <= 1'b0;
            snap_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            short_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            full_q       <= full_d;
            started_q    <= started_d;
            resync_q     <= resync_d;
            snap_q       <= snap_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            short_q      <= short_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        full_d       = full_q;
        started_d    = started_q;
        resync_d     = resync_q;
        snap_d       = snap_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        short_d      = short_q;
        overrun_d    = overrun_q;
        col_eff      = col_q;
        row_eff      = row_q;
        full_eff     = full_q;
        resync_eff   = resync_q;
        capture      = (state_q == S_LIVE) || (state_q == S_ARMED);

        // A frame_start restarts the counters in the same cycle so a coincident pixel lands at 0
        if (capture && frame_start) begin
            if (!full_q && started_q) short_d = 1'b1;
            col_eff    = '0;
            row_eff    = '0;
            full_eff   = 1'b0;
            resync_eff = 1'b0;
            col_d      = '0;
            row_d      = '0;
            full_d     = 1'b0;
            started_d  = 1'b0;
            resync_d   = 1'b0;
            if (state_q == S_ARMED) snap_d = 1'b1;
        end

        accept = capture && pix_valid && !resync_eff && !(state_q == S_ARMED && release_req);

`ifdef CAMERA_FRAME_WRITER_MIRROR_EN
        col_term = COL_W'(H_PIXELS - 1) - col_eff;
`else
        col_term = col_eff;
`endif

        if (accept && full_eff) overrun_d = 1'b1;
        if (accept && !full_eff) begin
            wr_en_d   = 1'b1;
            wr_data_d = pix_color;
            wr_addr_d = ADDR_W'(row_eff) * ADDR_W'(H_PIXELS) + ADDR_W'(col_term);
            started_d = 1'b1;
            if (col_eff == COL_W'(H_PIXELS - 1)) begin
                if (row_eff == ROW_W'(V_LINES - 1)) begin
                    // Counters saturate on the last pixel until the next frame_start
                    full_d       = 1'b1;
                    frame_done_d = 1'b1;
                    col_d        = col_eff;
                    row_d        = row_eff;
                end else begin
                    col_d = '0;
                    row_d = row_eff + ROW_W'(1);
                end
            end else begin
                col_d = col_eff + COL_W'(1);
                row_d = row_eff;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d   = S_LIVE;
                    col_d     = '0;
                    row_d     = '0;
                    full_d    = 1'b0;
                    started_d = 1'b0;
                    resync_d  = 1'b0;
                end
            end
            S_LIVE: begin
                if (snapshot_req && !release_req) begin
                    state_d = S_ARMED;
                    snap_d  = 1'b0;
                end
            end
            S_ARMED: begin
                if (release_req) begin
                    state_d   = S_LIVE;
                    resync_d  = 1'b1;
                    started_d = 1'b0;
                    snap_d    = 1'b0;
                end else if (frame_done_d && snap_d) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (release_req) begin
                    state_d   = S_LIVE;
                    resync_d  = 1'b1;
                    started_d = 1'b0;
                    snap_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = frame_done_q;
    assign frozen      = (state_q == S_HOLD);
    assign short_frame = short_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_camera_frame_writer.sv
// Scoreboard bench for camera_frame_writer on a reduced 64x32 frame; stimulus pushes
// expected writes, a negedge monitor pops and compares them.
module tb_camera_frame_writer;

    localparam int H  = 64;
    localparam int V  = 32;
    localparam int N  = H * V;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start, pix_valid, snapshot_req, release_req;
    logic [11:0]   pix_color;
    logic          wr_en, frame_done, frozen, short_frame, overrun;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;

    always #5 clk = ~clk;

    camera_frame_writer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .pix_color    (pix_color),
        .snapshot_req (snapshot_req),
        .release_req  (release_req),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_done   (frame_done),
        .frozen       (frozen),
        .short_frame  (short_frame),
        .overrun      (overrun)
    );

    typedef struct {
        longint addr;
        longint data;
        longint done;
        longint cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int eaddr(input int n);
        int r, c;
        r = n / H;
        c = n % H;
`ifdef CAMERA_FRAME_WRITER_MIRROR_EN
        return r * H + (H - 1 - c);
`else
        return r * H + c;
`endif
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every observed write must match the head of the expectation queue
    always @(negedge clk) begin
        exp_t e;
        if (rst && wr_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0d data 0x%h, expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", longint'(wr_addr), e.addr);
                check("wr_data", longint'(wr_data), e.data);
                check("frame_done", longint'(frame_done), e.done);
                check("write_cycle", cyc, e.cyc);
            end
        end else if (rst && frame_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_done_without_write: got 1, expected 0");
        end
    end

    task automatic push(input int a, input logic [11:0] d, input bit done);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.done = done;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit fs, input bit pv, input logic [11:0] c, input bit snap, input bit rel);
        frame_start  = fs;
        pix_valid    = pv;
        pix_color    = c;
        snapshot_req = snap;
        release_req  = rel;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        frame_start  = 1'b0;
        pix_valid    = 1'b0;
        pix_color    = '0;
        snapshot_req = 1'b0;
        release_req  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] color(input int i, input int tag);
        return 12'((i * 5 + tag * 97) & 12'hFFF);
    endfunction

    task automatic stream(input int first, input int count, input int tag, input bit fs_first, input bit expw);
        logic [11:0] c;
        for (int i = first; i < first + count; i++) begin
            c = color(i, tag);
            if (expw) push(eaddr(i), c, i == N - 1);
            drive(fs_first && (i == first), 1'b1, c, 1'b0, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, longint'(wr_en), 0);
        check({tag, "_wr_addr"}, longint'(wr_addr), 0);
        check({tag, "_wr_data"}, longint'(wr_data), 0);
        check({tag, "_frame_done"}, longint'(frame_done), 0);
        check({tag, "_frozen"}, longint'(frozen), 0);
        check({tag, "_short_frame"}, longint'(short_frame), 0);
        check({tag, "_overrun"}, longint'(overrun), 0);
    endtask

    initial begin
        logic [11:0] c;
        rst = 1'b0;
        frame_start = 1'b0; pix_valid = 1'b0; pix_color = '0;
        snapshot_req = 1'b0; release_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        // Pixels before the first frame_start are dropped
        stream(0, 5, 1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        push(eaddr(0), 12'h111, 1'b0); drive(1'b0, 1'b1, 12'h111, 1'b0, 1'b0);
        push(eaddr(1), 12'h222, 1'b0); drive(1'b0, 1'b1, 12'h222, 1'b0, 1'b0);
        push(eaddr(2), 12'h333, 1'b0); drive(1'b0, 1'b1, 12'h333, 1'b0, 1'b0);

        // Complete the frame, then one extra pixel while full
        stream(3, N - 3, 2, 1'b0, 1'b1);
        check("overrun_before_extra", longint'(overrun), 0);
        drive(1'b0, 1'b1, 12'hABC, 1'b0, 1'b0);
        idle(1);
        check("overrun_after_extra", longint'(overrun), 1);
        check("short_after_full_frame", longint'(short_frame), 0);

        // Snapshot requested mid-frame: that frame does not freeze, the next one does
        stream(0, 100, 3, 1'b1, 1'b1);
        c = color(100, 3);
        push(eaddr(100), c, 1'b0);
        drive(1'b0, 1'b1, c, 1'b1, 1'b0);
        stream(101, N - 101, 3, 1'b0, 1'b1);
        idle(1);
        check("frozen_after_armed_frame", longint'(frozen), 0);
        stream(0, N, 4, 1'b1, 1'b1);
        idle(1);
        check("frozen_after_snapshot", longint'(frozen), 1);
        stream(0, 50, 5, 1'b1, 1'b0);
        check("frozen_still", longint'(frozen), 1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        stream(0, 20, 6, 1'b0, 1'b0);
        check("frozen_after_release", longint'(frozen), 0);

        // Frame restarted after 1000 pixels
        stream(0, 1000, 7, 1'b1, 1'b1);
        check("short_before_restart", longint'(short_frame), 0);
        stream(0, 1, 8, 1'b1, 1'b1);
        check("short_after_restart", longint'(short_frame), 1);
        idle(2);

        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("reset_short", longint'(short_frame), 0);
        check("reset_overrun", longint'(overrun), 0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a frame
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        stream(0, 1501, 9, 1'b0, 1'b1);
        pix_valid = 1'b0;
        @(negedge clk);
        #2;
        check("pre_reset_wr_en", longint'(wr_en), 1);
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        stream(1501, 30, 10, 1'b0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        stream(0, 3, 11, 1'b0, 1'b1);
        idle(3);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", longint'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
